seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the taximeter's common-anode multi-digit 7-segment display.
- Stages a fare/distance word from the meter core on a load strobe and commits it to a shadow register only at a frame boundary, so a frame never shows a mix of old and new digits.
- Cycles the anodes one digit at a time, with a blanking gap between digits to prevent ghosting.
- Drives the active-low segment lines through a per-digit hex-to-7-segment decode.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_scan_tick.sv | 25 ++
 rtl/seg7_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the active-low hex-to-7-segment table for the taximeter display scanner.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Segments a..g on bits 6..0, active-low (0 = segment lit).
    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_tick.sv
// Dwell counter: counts 0..len-1 and pulses tick on the terminal count, then restarts.
module seg7_scan_tick #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] len,
    output logic          tick
);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == len - CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multi-digit common-anode 7-segment scan controller with frame-boundary commit of staged data.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*NDIG-1:0]   value_i,
    input  logic [NDIG-1:0]     dp_i,
    input  logic                load_i,
    output logic [NDIG-1:0]     an,
    output logic [6:0]          a_to_g,
    output logic                dp,
    output logic                frame_done,
    output logic                pending
);

    localparam int DMAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CW   = $clog2(DMAX + 1);
    localparam int IW   = $clog2(NDIG);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NDIG-1:0][3:0]   staged_val_q, shadow_val_q;
    logic [NDIG-1:0]        staged_dp_q, shadow_dp_q;
    logic                   pending_q;
    logic [NDIG-1:0]        an_d;
    logic [6:0]             seg_d;
    logic                   dp_d;
    logic [CW-1:0]          dwell_len;
    logic                   tick;
    logic                   wrap;
    logic [NDIG-1:0]        lz_dark;

    assign dwell_len = (state_q == ON) ? CW'(DIV) : CW'(BLANK_CYC);
    assign wrap      = tick && (state_q == ON) && (idx_q == IW'(NDIG - 1));

    seg7_scan_tick #(.CW(CW)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .len   (dwell_len),
        .tick  (tick)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more significant nibble are zero.
    always_comb begin
        logic run_zero;
        lz_dark  = '0;
        run_zero = 1'b1;
        for (int k = NDIG - 1; k > 0; k--) begin
            run_zero   = run_zero && (shadow_val_q[k] == 4'h0);
            lz_dark[k] = run_zero;
        end
    end
`else
    assign lz_dark = '0;
`endif

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        an_d    = '1;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;

        case (state_q)
            BLANK: begin
                if (tick) state_d = ON;
            end
            ON: begin
                if (tick) begin
                    state_d = BLANK;
                    idx_d   = wrap ? '0 : idx_q + IW'(1);
                end
            end
            default: state_d = BLANK;
        endcase

        // Outputs are computed for the state being entered so they register together with it.
        if (state_d == ON && !lz_dark[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = seg7_decode(shadow_val_q[idx_d]);
            dp_d        = ~shadow_dp_q[idx_d];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BLANK;
            idx_q      <= '0;
            an         <= '1;
            a_to_g     <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            an         <= an_d;
            a_to_g     <= seg_d;
            dp         <= dp_d;
            frame_done <= wrap;
        end
    end

    // A load in the wrap cycle commits the old staged word and keeps the new one pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged_val_q <= '0;
            staged_dp_q  <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
        end else begin
            if (load_i) begin
                staged_val_q <= value_i;
                staged_dp_q  <= dp_i;
            end
            if (wrap && pending_q) begin
                shadow_val_q <= staged_val_q;
                shadow_dp_q  <= staged_dp_q;
            end
            if (load_i) begin
                pending_q <= 1'b1;
            end else if (wrap) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIG=4, DIV=4, BLANK_CYC=2 (24-cycle frame).
// Expectations for leading-zero digits follow SEG7_LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg7_scan_ctrl;

    localparam int NDIG      = 4;
    localparam int DIV       = 4;
    localparam int BLANK_CYC = 2;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b1100000;
    localparam logic [6:0] SC = 7'b0110001;
    localparam logic [6:0] SD = 7'b1000010;
    localparam logic [6:0] SE = 7'b0110000;
    localparam logic [6:0] OFF = 7'b1111111;

    logic                clk;
    logic                rst_n;
    logic [4*NDIG-1:0]   value_i;
    logic [NDIG-1:0]     dp_i;
    logic                load_i;
    logic [NDIG-1:0]     an;
    logic [6:0]          a_to_g;
    logic                dp;
    logic                frame_done;
    logic                pending;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    seg7_scan_ctrl #(
        .NDIG      (NDIG),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_i    (value_i),
        .dp_i       (dp_i),
        .load_i     (load_i),
        .an         (an),
        .a_to_g     (a_to_g),
        .dp         (dp),
        .frame_done (frame_done),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic check_digit(input string tag, input int k, input logic [6:0] seg,
                               input logic dp_pin, input bit dark);
        logic [3:0] exp_an;
        exp_an = 4'b1111;
        if (!dark) exp_an[k] = 1'b0;
        check({tag, "/an"},  32'(an),     32'(exp_an));
        check({tag, "/seg"}, 32'(a_to_g), 32'(dark ? OFF : seg));
        check({tag, "/dp"},  32'(dp),     32'(dark ? 1'b1 : dp_pin));
    endtask

    task automatic check_blank(input string tag);
        check({tag, "/an"},  32'(an),     32'hF);
        check({tag, "/seg"}, 32'(a_to_g), 32'(OFF));
        check({tag, "/dp"},  32'(dp),     32'h1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value_i = v;
        dp_i    = d;
        load_i  = 1'b1;
        step();
        load_i  = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        value_i = '0;
        dp_i    = '0;
        load_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_blank("rst");
        check("rst/frame_done", 32'(frame_done), 32'h0);
        check("rst/pending",    32'(pending),    32'h0);
        rst_n = 1'b1;
        cyc   = 0;

        // Free-running scan of the reset (all-zero) shadow.
        check_blank("c0");
        goto(1);  check_blank("c1");
        goto(2);  check_digit("c2_d0", 0, S0, 1'b1, 1'b0);
        goto(5);  check_digit("c5_d0", 0, S0, 1'b1, 1'b0);
        goto(6);  check_blank("c6");
        goto(8);  check_digit("c8_d1", 1, S0, 1'b1, LZ);
        goto(23); check("c23/frame_done", 32'(frame_done), 32'h0);
                  check_digit("c23_d3", 3, S0, 1'b1, LZ);
        goto(24); check("c24/frame_done", 32'(frame_done), 32'h1);
                  check_blank("c24");
        goto(25); check("c25/frame_done", 32'(frame_done), 32'h0);

        // Mid-frame load: held off until the wrap.
        goto(30); check("t2/pend_before", 32'(pending), 32'h0);
        do_load(16'h12A7, 4'b0100);
        check("t2/pend_after", 32'(pending), 32'h1);
        goto(44); check_digit("t2_old_d3", 3, S0, 1'b1, LZ);
        goto(47); check("t2/pend_c47", 32'(pending), 32'h1);
        goto(48); check("t2/frame_done", 32'(frame_done), 32'h1);
                  check("t2/pend_clear", 32'(pending), 32'h0);
        goto(50); check_digit("t2_d0", 0, S7, 1'b1, 1'b0);
        goto(56); check_digit("t2_d1", 1, SA, 1'b1, 1'b0);
        goto(62); check_digit("t2_d2", 2, S2, 1'b0, 1'b0);
        goto(68); check_digit("t2_d3", 3, S1, 1'b1, 1'b0);

        // Two loads in one frame: only the latest is shown.
        goto(75); do_load(16'h1111, 4'b0000);
        goto(80); do_load(16'h2222, 4'b0000);
        goto(92); check_digit("t3_old_d3", 3, S1, 1'b1, 1'b0);
        goto(98);  check_digit("t3_d0", 0, S2, 1'b1, 1'b0);
        goto(104); check_digit("t3_d1", 1, S2, 1'b1, 1'b0);
        goto(110); check_digit("t3_d2", 2, S2, 1'b1, 1'b0);

        // Load in the wrap cycle while a value is already pending.
        do_load(16'h9876, 4'b0000);
        goto(116); check_digit("t3_d3", 3, S2, 1'b1, 1'b0);
        goto(119); check("t4/pend_wrap", 32'(pending), 32'h1);
        do_load(16'hBCDE, 4'b1000);
        check("t4/frame_done", 32'(frame_done), 32'h1);
        check("t4/pend_kept",  32'(pending),    32'h1);
        goto(122); check_digit("t4_d0", 0, S6, 1'b1, 1'b0);
        goto(140); check_digit("t4_d3", 3, S9, 1'b1, 1'b0);
        goto(144); check("t4/pend_clear", 32'(pending), 32'h0);
                   check("t4/frame_done2", 32'(frame_done), 32'h1);
        goto(146); check_digit("t4n_d0", 0, SE, 1'b1, 1'b0);
        goto(152); check_digit("t4n_d1", 1, SD, 1'b1, 1'b0);
        goto(158); check_digit("t4n_d2", 2, SC, 1'b1, 1'b0);
        goto(164); check_digit("t4n_d3", 3, SB, 1'b0, 1'b0);

        // Leading zeros: dark only when the option is built in.
        goto(170); do_load(16'h0050, 4'b0000);
        goto(194); check_digit("t6_d0", 0, S0, 1'b1, 1'b0);
        goto(200); check_digit("t6_d1", 1, S5, 1'b1, 1'b0);
        goto(206); check_digit("t6_d2", 2, S0, 1'b1, LZ);
        goto(212); check_digit("t6_d3", 3, S0, 1'b1, LZ);

        // Reset during an ON dwell drops the staged value.
        goto(219); do_load(16'hFFFF, 4'hF);
        check_digit("t5_pre_d0", 0, S0, 1'b1, 1'b0);
        check("t5/pend_pre", 32'(pending), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_blank("t5_rst");
        check("t5/pend_rst",  32'(pending),    32'h0);
        check("t5/fd_rst",    32'(frame_done), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        check_blank("t5_c0");
        goto(1);  check_blank("t5_c1");
        goto(2);  check_digit("t5_c2_d0", 0, S0, 1'b1, 1'b0);
        goto(24); check("t5/frame_done", 32'(frame_done), 32'h1);
                  check("t5/pend_lost",  32'(pending),    32'h0);
        goto(26); check_digit("t5_c26_d0", 0, S0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
